// File: rtl/dnn_argmax_pkg.sv
// Shared types and helpers for the sequential argmax classifier that follows
// the 10-output inference engine.
package dnn_argmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int N_CLASSES_DEF = 10;
  localparam int IDX_W         = $clog2(N_CLASSES_DEF);

  // The low `width` bits of the result are the two's-complement minimum.
  function automatic logic [31:0] most_neg(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dnn_argmax_cmp.sv
// Single-element running-max update: folds one signed score into the current
// best/second/class/tie state. Purely combinational.
module dnn_argmax_cmp #(
  parameter int DATA_WIDTH = 9,
  parameter int IDX_W      = 4
) (
  input  logic [DATA_WIDTH-1:0] score,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] best,
  input  logic [DATA_WIDTH-1:0] second,
  input  logic [IDX_W-1:0]      cls,
  input  logic                  tie,
  output logic [DATA_WIDTH-1:0] best_nxt,
  output logic [DATA_WIDTH-1:0] second_nxt,
  output logic [IDX_W-1:0]      cls_nxt,
  output logic                  tie_nxt
);

  always_comb begin
    best_nxt   = best;
    second_nxt = second;
    cls_nxt    = cls;
    tie_nxt    = tie;
    if ($signed(score) > $signed(best)) begin
      second_nxt = best;
      best_nxt   = score;
      cls_nxt    = idx;
      tie_nxt    = 1'b0;
    end else if (score == best) begin
      // Equal score: lower index keeps the class, margin collapses to zero.
      tie_nxt    = 1'b1;
      second_nxt = score;
    end else if ($signed(score) > $signed(second)) begin
      second_nxt = score;
    end
  end

endmodule

// File: rtl/dnn_argmax_seq.sv
// Captures the engine's score vector on done, scans it one element per cycle
// and presents class/max/margin/tie through a valid/ready handshake.
module dnn_argmax_seq
  import dnn_argmax_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int N_CLASSES  = N_CLASSES_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic [N_CLASSES-1:0][DATA_WIDTH-1:0] in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(N_CLASSES)-1:0]        out_class,
  output logic signed [DATA_WIDTH-1:0]        out_max,
  output logic [DATA_WIDTH:0]                 out_margin,
  output logic                                out_tie,
  output logic [CNT_WIDTH-1:0]                out_count
);

  localparam int CW = $clog2(N_CLASSES);
  localparam logic [DATA_WIDTH-1:0] NEG  = DATA_WIDTH'(most_neg(DATA_WIDTH));
  localparam logic [CW-1:0]         LAST = CW'(N_CLASSES - 1);

  state_e                  state_q, state_d;
  logic                    armed_q, armed_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   best_q, best_d;
  logic [DATA_WIDTH-1:0]   second_q, second_d;
  logic [CW-1:0]           cls_q, cls_d;
  logic                    tie_q, tie_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [CW-1:0]           out_class_q, out_class_d;
  logic [DATA_WIDTH-1:0]   out_max_q, out_max_d;
  logic [DATA_WIDTH:0]     out_margin_q, out_margin_d;
  logic                    out_tie_q, out_tie_d;
  logic [CNT_WIDTH-1:0]    out_count_q, out_count_d;

  logic [DATA_WIDTH-1:0]   scores_q [N_CLASSES];
  logic                    capture;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   cmp_best;
  logic [DATA_WIDTH-1:0]   cmp_second;
  logic [CW-1:0]           cmp_cls;
  logic                    cmp_tie;

  assign capture = in_valid && in_ready_q;
  assign accept  = (state_q == HOLD) && out_valid_q && out_ready;

  // Score storage is loaded only at capture, so it needs no reset.
  generate
    for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_scores
      always_ff @(posedge clk) begin
        if (capture) scores_q[gi] <= in_data[gi];
      end
    end
  endgenerate

  dnn_argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (CW)
  ) u_cmp (
    .score      (scores_q[idx_q]),
    .idx        (idx_q),
    .best       (best_q),
    .second     (second_q),
    .cls        (cls_q),
    .tie        (tie_q),
    .best_nxt   (cmp_best),
    .second_nxt (cmp_second),
    .cls_nxt    (cmp_cls),
    .tie_nxt    (cmp_tie)
  );

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    idx_d        = idx_q;
    best_d       = best_q;
    second_d     = second_q;
    cls_d        = cls_q;
    tie_d        = tie_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_max_d    = out_max_q;
    out_margin_d = out_margin_q;
    out_tie_d    = out_tie_q;
    out_count_d  = out_count_q;

    // A held-high done level must drop before another capture is allowed.
    if (capture)        armed_d = 1'b0;
    else if (!in_valid) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (capture) begin
          idx_d    = '0;
          best_d   = NEG;
          second_d = NEG;
          cls_d    = '0;
          tie_d    = 1'b0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        best_d   = cmp_best;
        second_d = cmp_second;
        cls_d    = cmp_cls;
        tie_d    = cmp_tie;
        idx_d    = idx_q + CW'(1);
        if (idx_q == LAST) begin
          state_d      = HOLD;
          out_valid_d  = 1'b1;
          out_class_d  = cmp_cls;
          out_max_d    = cmp_best;
          out_margin_d = {cmp_best[DATA_WIDTH-1], cmp_best}
                       - {cmp_second[DATA_WIDTH-1], cmp_second};
          out_tie_d    = cmp_tie;
        end
      end
      HOLD: begin
        if (accept) begin
          out_valid_d = 1'b0;
          if (out_count_q != '1) out_count_d = out_count_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      state_d      = IDLE;
      armed_d      = 1'b1;
      idx_d        = '0;
      best_d       = '0;
      second_d     = '0;
      cls_d        = '0;
      tie_d        = 1'b0;
      out_valid_d  = 1'b0;
      out_class_d  = '0;
      out_max_d    = '0;
      out_margin_d = '0;
      out_tie_d    = 1'b0;
      out_count_d  = '0;
    end

    in_ready_d = (state_d == IDLE) && armed_d && !reset;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      armed_q      <= 1'b1;
      idx_q        <= '0;
      best_q       <= '0;
      second_q     <= '0;
      cls_q        <= '0;
      tie_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_max_q    <= '0;
      out_margin_q <= '0;
      out_tie_q    <= 1'b0;
      out_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      second_q     <= second_d;
      cls_q        <= cls_d;
      tie_q        <= tie_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_max_q    <= out_max_d;
      out_margin_q <= out_margin_d;
      out_tie_q    <= out_tie_d;
      out_count_q  <= out_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_max    = out_max_q;
  assign out_margin = out_margin_q;
  assign out_tie    = out_tie_q;
  assign out_count  = out_count_q;

endmodule
